// File: rtl/ipr_write_master.sv
// IPR write-port initiator: stages producer words in a circular buffer and issues one
// REQ/GNT/RVALID write at a time. Optional grant-timeout flag under IPR_WR_TIMEOUT_EN.
module ipr_write_master #(
    parameter int unsigned DW          = 32,
    parameter int unsigned BUF_DEPTH   = 4,
    parameter int unsigned BULK_NUMBER = 10,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic          w_clk,
    input  logic          w_rst_n,

    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,

    output logic          m_req,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    input  logic          m_gnt,
    input  logic          m_rvalid,

    input  logic          err_clr,
    output logic          busy,
    output logic          bulk_done,
    output logic [15:0]   words_sent,
    output logic          error_flag
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (BULK_NUMBER > 1) ? $clog2(BULK_NUMBER) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_d;

    logic [DW-1:0]   r_mem [BUF_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_words_sent;
    logic [BW-1:0]   r_bulk_cnt;
    logic            r_bulk_done;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    // Staging buffer; ready comes only from the registered count so a pop cannot open a
    // slot for a push in the same cycle.
    assign w_full  = (r_count == CW'(BUF_DEPTH));
    assign w_empty = (r_count == '0);
    assign s_ready = ~w_full;
    assign w_push  = s_valid & ~w_full;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head stays put until the completion pops it, so data is stable through REQ and WAIT.
    assign m_wdata = r_mem[r_rptr];

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        m_req     = 1'b0;
        m_we      = 1'b0;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                m_req = 1'b1;
                m_we  = 1'b1;
                if (m_gnt) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (m_rvalid) begin
                    w_pop     = 1'b1;
                    w_state_d = (r_count > CW'(1)) ? StReq : StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_words_sent <= '0;
            r_bulk_cnt   <= '0;
            r_bulk_done  <= 1'b0;
        end else begin
            r_bulk_done <= 1'b0;
            if (w_pop) begin
                r_words_sent <= r_words_sent + 16'd1;
                if (r_bulk_cnt == BW'(BULK_NUMBER - 1)) begin
                    r_bulk_cnt  <= '0;
                    r_bulk_done <= 1'b1;
                end else begin
                    r_bulk_cnt <= r_bulk_cnt + BW'(1);
                end
            end
        end
    end

    assign words_sent = r_words_sent;
    assign bulk_done  = r_bulk_done;
    assign busy       = ~w_empty | (r_state != StIdle);

`ifdef IPR_WR_TIMEOUT_EN
    localparam int unsigned SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [SW-1:0] r_stall_cnt;
    logic          r_error;
    logic          w_stall;
    logic          w_err_set;

    assign w_stall   = (r_state == StReq) & ~m_gnt;
    assign w_err_set = w_stall & (r_stall_cnt == SW'(TIMEOUT - 1));

    // Counter saturates at the threshold so a continuing stall keeps re-asserting the flag.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stall_cnt <= '0;
            r_error     <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (!w_err_set) begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
            end
            r_error <= w_err_set | (r_error & ~err_clr);
        end
    end

    assign error_flag = r_error;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign error_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_ipr_write_master.sv
// Scoreboard bench for ipr_write_master: stimulus queues expected write data and bulk
// boundaries; a negedge monitor checks them whenever the DUT presents a handshake/pulse.
module tb_ipr_write_master;

    localparam int DW = 32;

`ifdef IPR_WR_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          w_clk = 1'b0;
    logic          w_rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_req;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic          err_clr;
    logic          busy;
    logic          bulk_done;
    logic [15:0]   words_sent;
    logic          error_flag;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_bulk_q[$];
    int            req_cycles = 0;
    int            cyc = 0;
    int            hs_last = 0;
    bit            gap_en = 1'b0;
    bit            gap_first = 1'b1;
    int            gap_bad = 0;
    bit            rvalid_hold = 1'b0;
    bit            rsp_hs = 1'b0;

    ipr_write_master #(
        .DW         (DW),
        .BUF_DEPTH  (4),
        .BULK_NUMBER(10),
        .TIMEOUT    (8)
    ) u_dut (
        .w_clk     (w_clk),
        .w_rst_n   (w_rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .err_clr   (err_clr),
        .busy      (busy),
        .bulk_done (bulk_done),
        .words_sent(words_sent),
        .error_flag(error_flag)
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // IPR side: completion arrives the cycle after a granted request.
    always begin
        @(negedge w_clk);
        rsp_hs = m_req && m_gnt && w_rst_n;
        @(posedge w_clk);
        #1;
        m_rvalid = rsp_hs && !rvalid_hold;
    end

    // Monitor / scoreboard.
    always begin
        @(negedge w_clk);
        cyc++;
        if (w_rst_n) begin
            if (m_req) req_cycles++;
            if (m_req && m_gnt) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got %0h expected none", m_wdata);
                end else begin
                    check("wdata_order", m_wdata, exp_q.pop_front());
                end
                check("m_we_on_grant", m_we, 1'b1);
                if (gap_en) begin
                    if (!gap_first && (cyc - hs_last != 2)) gap_bad++;
                    gap_first = 1'b0;
                end
                hs_last = cyc;
            end
            if (bulk_done) begin
                if (exp_bulk_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_bulk_done: got words_sent %0d expected no pulse",
                             words_sent);
                end else begin
                    check("bulk_done_at", words_sent, exp_bulk_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int budget = 300;
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        while (budget > 0) begin
            @(negedge w_clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            budget--;
        end
        if (ok) exp_q.push_back(d);
        else begin
            n_checks++;
            $display("FAIL push_timeout: got s_ready 0 expected 1 for word %0h", d);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_sent(input string name, input int n);
        int budget = 400;
        while (budget > 0 && words_sent != 16'(n)) begin
            @(negedge w_clk);
            budget--;
        end
        check(name, words_sent, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b1);
        check({tag, "_m_req"}, m_req, 1'b0);
        check({tag, "_m_we"}, m_we, 1'b0);
        check({tag, "_m_wdata"}, m_wdata, 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_bulk_done"}, bulk_done, 1'b0);
        check({tag, "_words_sent"}, words_sent, 0);
        check({tag, "_error_flag"}, error_flag, 1'b0);
    endtask

    task automatic do_reset();
        w_rst_n     = 1'b0;
        s_valid     = 1'b0;
        m_gnt       = 1'b0;
        err_clr     = 1'b0;
        rvalid_hold = 1'b0;
        exp_q.delete();
        exp_bulk_q.delete();
        repeat (2) tick();
        w_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int n;
        w_rst_n  = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_gnt    = 1'b0;
        err_clr  = 1'b0;
        m_rvalid = 1'b0;
        #12;
        check_reset_vals("rst");
        repeat (2) tick();
        w_rst_n = 1'b1;
        tick();

        // Single word, immediate grant and completion.
        m_gnt = 1'b1;
        r0 = req_cycles;
        push(32'hA5A5_0001);
        wait_sent("t1_words_sent", 1);
        repeat (3) @(negedge w_clk);
        check("t1_req_cycles", req_cycles - r0, 1);
        check("t1_busy_after", busy, 1'b0);

        // Grant withheld: buffer fills to four, request and head held.
        tick();
        m_gnt = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h2000_0000 + i);
        @(negedge w_clk);
        check("t2_s_ready_full", s_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge w_clk);
            check("t2_req_held", m_req, 1'b1);
            check("t2_wdata_held", m_wdata, 32'h2000_0000);
        end
        tick();
        m_gnt = 1'b1;
        push(32'h2000_0004);
        push(32'h2000_0005);
        wait_sent("t2_words_sent", 7);

        // Stream of 20 words: two bulk boundaries, one request every two cycles.
        do_reset();
        m_gnt = 1'b1;
        exp_bulk_q.push_back(10);
        exp_bulk_q.push_back(20);
        gap_bad   = 0;
        gap_first = 1'b1;
        gap_en    = 1'b1;
        for (int i = 0; i < 20; i++) push(32'h3000_0000 + i);
        wait_sent("t3_words_sent", 20);
        repeat (3) @(negedge w_clk);
        gap_en = 1'b0;
        check("t3_gap_not_2", gap_bad, 0);
        check("t3_bulk_pending", exp_bulk_q.size(), 0);

        // Grant stall: flag rises after the eighth stall cycle when the timeout is built in.
        do_reset();
        m_gnt = 1'b0;
        push(32'h4000_0001);
        n = 0;
        for (int b = 0; b < 100 && n < 10; b++) begin
            @(negedge w_clk);
            if (m_req) begin
                n++;
                if (n == 8) check("t4_err_at_8", error_flag, 1'b0);
                if (n == 9) check("t4_err_at_9", error_flag, EXP_ERR);
            end
        end
        check("t4_stall_cycles", n, 10);
        tick();
        m_gnt = 1'b1;
        wait_sent("t4_words_sent", 1);
        check("t4_err_sticky", error_flag, EXP_ERR);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge w_clk);
        check("t4_err_cleared", error_flag, 1'b0);

        // Reset while waiting for completion with three words buffered.
        do_reset();
        m_gnt       = 1'b1;
        rvalid_hold = 1'b1;
        for (int i = 1; i <= 3; i++) push(32'h5000_0000 + i);
        repeat (2) @(negedge w_clk);
        check("t5_in_wait_req", m_req, 1'b0);
        check("t5_in_wait_busy", busy, 1'b1);
        w_rst_n = 1'b0;
        #1;
        check_reset_vals("t5_rst");
        exp_q.delete();
        tick();
        w_rst_n     = 1'b1;
        rvalid_hold = 1'b0;
        r0 = req_cycles;
        repeat (10) @(negedge w_clk);
        check("t5_no_req_after", req_cycles - r0, 0);
        check("t5_busy_after", busy, 1'b0);
        tick();
        push(32'h5000_0004);
        wait_sent("t5_words_sent", 1);

        // Push coinciding with a completion pop at count 2.
        do_reset();
        m_gnt = 1'b1;
        push(32'h6000_0001);
        push(32'h6000_0002);
        tick();
        push(32'h6000_0003);
        @(negedge w_clk);
        check("t6_req_again", m_req, 1'b1);
        check("t6_head_older", m_wdata, 32'h6000_0002);
        check("t6_s_ready", s_ready, 1'b1);
        wait_sent("t6_words_sent", 3);
        repeat (3) @(negedge w_clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
